// File: rtl/regfile_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_pkg
// Description : Shared types and helpers for the register-file writeback
//               queue. Defines the queued write entry (address + data) and a
//               one-hot decode of a register address, used to build the
//               per-register pending mask.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_wb_pkg;

    localparam int c_addr_width = 5;
    localparam int c_data_width = 32;
    localparam int c_num_regs   = 2 ** c_addr_width;

    // One queued register write.
    typedef struct packed {
        logic [c_addr_width-1:0] addr;
        logic [c_data_width-1:0] data;
    } wb_entry_t;

    // One-hot decode of a register address.
    function automatic logic [c_num_regs-1:0] addr_onehot(input logic [c_addr_width-1:0] addr);
        logic [c_num_regs-1:0] v;
        v       = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage : regfile_wb_pkg
`default_nettype wire

// File: rtl/regfile_wb_queue_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Circular buffer of writeback entries. Accepts 0, 1 or 2
//               pushes per cycle (already compacted: entry0 is always the
//               older one) and 0 or 1 pop per cycle. Exposes the address and
//               valid bit of every slot so the parent can build a pending mask.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               i_push_cnt         - number of entries pushed this edge (0..2)
//               i_push_entry0/1    - first / second pushed entry
//               i_pop              - pop head this edge (ignored when empty)
//               o_head             - current head entry
//               o_count            - occupied entries
//               o_entry_addr       - address held in each slot
//               o_entry_valid      - slot currently holds a queued write
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [1:0]                            i_push_cnt,
    input  wb_entry_t                             i_push_entry0,
    input  wb_entry_t                             i_push_entry1,
    input  logic                                  i_pop,
    output wb_entry_t                             o_head,
    output logic [$clog2(DEPTH):0]                o_count,
    output logic [DEPTH-1:0][c_addr_width-1:0]    o_entry_addr,
    output logic [DEPTH-1:0]                      o_entry_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t          r_mem_q [DEPTH];
    wb_entry_t          w_mem_d [DEPTH];
    logic [PTR_W-1:0]   r_wptr_q, w_wptr_d;
    logic [PTR_W-1:0]   r_rptr_q, w_rptr_d;
    logic [CNT_W-1:0]   r_count_q, w_count_d;
    logic [PTR_W-1:0]   w_wptr_inc;
    logic               w_pop;

    assign w_wptr_inc = r_wptr_q + PTR_W'(1);

    always_comb begin
        w_mem_d   = r_mem_q;
        w_pop     = i_pop && (r_count_q != '0);
        // The parent only pushes when at least two slots are free, so both
        // writes always land in empty slots.
        if (i_push_cnt != 2'd0) begin
            w_mem_d[r_wptr_q] = i_push_entry0;
        end
        if (i_push_cnt == 2'd2) begin
            w_mem_d[w_wptr_inc] = i_push_entry1;
        end
        // Pointer arithmetic wraps naturally because DEPTH is a power of two.
        w_wptr_d  = r_wptr_q + PTR_W'(i_push_cnt);
        w_rptr_d  = r_rptr_q + PTR_W'(w_pop);
        w_count_d = r_count_q + CNT_W'(i_push_cnt) - CNT_W'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr_q  <= '0;
            r_rptr_q  <= '0;
            r_count_q <= '0;
        end else begin
            r_wptr_q  <= w_wptr_d;
            r_rptr_q  <= w_rptr_d;
            r_count_q <= w_count_d;
        end
    end

    // Storage needs no reset; slot validity is derived from the pointers.
    always_ff @(posedge clk) begin
        r_mem_q <= w_mem_d;
    end

    assign o_head  = r_mem_q[r_rptr_q];
    assign o_count = r_count_q;

    // A slot is valid when its distance from the read pointer is below count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PTR_W-1:0] w_off;
            assign w_off             = PTR_W'(gi) - r_rptr_q;
            assign o_entry_addr[gi]  = r_mem_q[gi].addr;
            assign o_entry_valid[gi] = ({1'b0, w_off} < r_count_q);
        end
    endgenerate

endmodule : wb_fifo
`default_nettype wire

// File: rtl/regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_queue
// Description : Writeback queue between two execution lanes and the register
//               file write port. Buffers up to two writes per cycle in program
//               order (lane 0 older), drains one per cycle into an output
//               register that drives WE3/ADDR3/WD3, and exports a pending mask
//               of registers with writes still in flight. Writes to x0 are
//               dropped. ADDR_WIDTH/DATA_WIDTH must match the package entry.
// Ports       : clk, rst                    - clock, sync active-high reset
//               in0_valid/addr/data         - lane 0 write (older)
//               in1_valid/addr/data         - lane 1 write (younger)
//               in_ready                    - both lanes can be accepted
//               we/waddr/wdata              - register file write port
//               pending                     - per-register in-flight mask
//               count                       - queued entries (excl. output)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_queue
    import regfile_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in0_valid,
    input  logic [ADDR_WIDTH-1:0]     in0_addr,
    input  logic [DATA_WIDTH-1:0]     in0_data,
    input  logic                      in1_valid,
    input  logic [ADDR_WIDTH-1:0]     in1_addr,
    input  logic [DATA_WIDTH-1:0]     in1_data,
    output logic                      in_ready,
    output logic                      we,
    output logic [ADDR_WIDTH-1:0]     waddr,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [2**ADDR_WIDTH-1:0]  pending,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int              CNT_W       = $clog2(DEPTH) + 1;
    // Ready while at least two slots are free, i.e. count <= DEPTH-2.
    localparam logic [CNT_W-1:0] c_ready_max = CNT_W'(DEPTH - 2);

    logic [CNT_W-1:0]                  w_count;
    wb_entry_t                         w_head;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0]  w_entry_addr;
    logic [DEPTH-1:0]                  w_entry_valid;

    wb_entry_t          w_e0, w_e1, w_push_e0;
    logic               w_acc0, w_acc1, w_pop;
    logic [1:0]         w_push_cnt;

    logic                    r_we_q,    w_we_d;
    logic [ADDR_WIDTH-1:0]   r_waddr_q, w_waddr_d;
    logic [DATA_WIDTH-1:0]   r_wdata_q, w_wdata_d;
    logic [2**ADDR_WIDTH-1:0] w_pending;

    // Registered count only: no combinational path from the valid inputs.
    assign in_ready = (w_count <= c_ready_max);

    assign w_e0.addr = in0_addr;
    assign w_e0.data = in0_data;
    assign w_e1.addr = in1_addr;
    assign w_e1.data = in1_data;

    always_comb begin
        w_acc0     = in_ready && in0_valid && (in0_addr != '0);
        w_acc1     = in_ready && in1_valid && (in1_addr != '0);
        w_push_cnt = {1'b0, w_acc0} + {1'b0, w_acc1};
        // Compact so the first pushed slot is always the oldest accepted write.
        w_push_e0  = w_acc0 ? w_e0 : w_e1;
        w_pop      = (w_count != '0);
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .i_push_cnt    (w_push_cnt),
        .i_push_entry0 (w_push_e0),
        .i_push_entry1 (w_e1),
        .i_pop         (w_pop),
        .o_head        (w_head),
        .o_count       (w_count),
        .o_entry_addr  (w_entry_addr),
        .o_entry_valid (w_entry_valid)
    );

    // Output register: address/data hold their last value on idle cycles.
    always_comb begin
        w_we_d    = w_pop;
        w_waddr_d = w_pop ? w_head.addr : r_waddr_q;
        w_wdata_d = w_pop ? w_head.data : r_wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we_q    <= 1'b0;
            r_waddr_q <= '0;
            r_wdata_q <= '0;
        end else begin
            r_we_q    <= w_we_d;
            r_waddr_q <= w_waddr_d;
            r_wdata_q <= w_wdata_d;
        end
    end

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i]) begin
                w_pending = w_pending | addr_onehot(w_entry_addr[i]);
            end
        end
        if (r_we_q) begin
            w_pending = w_pending | addr_onehot(r_waddr_q);
        end
        // x0 is never written, so it is never pending.
        w_pending[0] = 1'b0;
    end

    assign we      = r_we_q;
    assign waddr   = r_waddr_q;
    assign wdata   = r_wdata_q;
    assign pending = w_pending;
    assign count   = w_count;

endmodule : regfile_wb_queue
`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_queue
// Description : Self-checking bench for regfile_wb_queue. Accepted writes are
//               pushed into an expected-write queue; a negedge monitor pops
//               and compares every register file write and checks pending,
//               count and in_ready against the in-flight set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_queue;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int NREGS = 2 ** AW;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in0_valid, in1_valid;
    logic [AW-1:0]           in0_addr, in1_addr;
    logic [DW-1:0]           in0_data, in1_data;
    logic                    in_ready, we;
    logic [AW-1:0]           waddr;
    logic [DW-1:0]           wdata;
    logic [NREGS-1:0]        pending;
    logic [$clog2(DEPTH):0]  count;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t           exp_q[$];
    logic [DW-1:0]  model_rf [NREGS];
    logic [DW-1:0]  dut_rf   [NREGS];
    int             n_checks = 0;
    int             n_fail   = 0;
    int             n_writes = 0;
    bit             mon_en   = 1'b0;

    regfile_wb_queue #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_addr  (in0_addr),
        .in0_data  (in0_data),
        .in1_valid (in1_valid),
        .in1_addr  (in1_addr),
        .in1_data  (in1_data),
        .in_ready  (in_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .pending   (pending),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: everything in exp_q is in flight (queued or on the output).
    logic [NREGS-1:0] m_exp_pend;
    int               m_exp_cnt;
    exp_t             m_e;
    always @(negedge clk) begin
        if (mon_en) begin
            m_exp_pend = '0;
            foreach (exp_q[i]) m_exp_pend[exp_q[i].addr] = 1'b1;
            m_exp_pend[0] = 1'b0;
            m_exp_cnt = exp_q.size() - (we ? 1 : 0);
            chk("pending", pending, m_exp_pend);
            chk("count", count, m_exp_cnt);
            chk("in_ready", in_ready, ((DEPTH - m_exp_cnt) >= 2));
            if (we === 1'b1) begin
                n_writes++;
                dut_rf[waddr] = wdata;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d data %0h expected no write at %0t",
                             waddr, wdata, $time);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("waddr", waddr, m_e.addr);
                    chk("wdata", wdata, m_e.data);
                    model_rf[m_e.addr] = m_e.data;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic cycle(input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        int waits = 0;
        in0_valid = v0; in0_addr = a0; in0_data = d0;
        in1_valid = v1; in1_addr = a1; in1_data = d1;
        while (in_ready !== 1'b1 && waits < 50) begin
            @(posedge clk); #1;
            waits++;
        end
        if (in_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: got in_ready=%b expected 1 within 50 cycles", in_ready);
        end else begin
            @(posedge clk);
            if (v0 && a0 != '0) exp_q.push_back(exp_t'({a0, d0}));
            if (v1 && a1 != '0) exp_q.push_back(exp_t'({a1, d1}));
            #1;
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int w0;
        for (int i = 0; i < NREGS; i++) begin
            model_rf[i] = '0;
            dut_rf[i]   = '0;
        end
        in0_valid = 1'b0; in0_addr = '0; in0_data = '0;
        in1_valid = 1'b0; in1_addr = '0; in1_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", we, 0);
        chk("rst_count", count, 0);
        chk("rst_pending", pending, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single write: latency and pending lifetime
        cycle(1, 5'd5, 32'hA5A5_0001, 0, 5'd0, 32'h0);
        chk("t1_we_early", we, 0);
        chk("t1_pend5_q", pending[5], 1);
        idle(1);
        chk("t1_we", we, 1);
        chk("t1_waddr", waddr, 5);
        chk("t1_wdata", wdata, 32'hA5A5_0001);
        chk("t1_pend5_out", pending[5], 1);
        idle(1);
        chk("t1_we_done", we, 0);
        chk("t1_pend5_clr", pending[5], 0);
        chk("t1_wdata_hold", wdata, 32'hA5A5_0001);

        // Same address on both lanes: lane 1 lands last
        cycle(1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
        chk("t2_pend3_a", pending[3], 1);
        idle(1);
        chk("t2_wdata0", wdata, 32'h11);
        chk("t2_pend3_b", pending[3], 1);
        idle(1);
        chk("t2_wdata1", wdata, 32'h22);
        chk("t2_we1", we, 1);
        chk("t2_pend3_c", pending[3], 1);
        idle(1);
        chk("t2_pend3_clr", pending[3], 0);
        chk("t2_rf3", dut_rf[3], 32'h22);

        // x0 on lane 0 is dropped
        w0 = n_writes;
        cycle(1, 5'd0, 32'hDEAD, 1, 5'd7, 32'h33);
        idle(4);
        chk("t3_writes", n_writes - w0, 1);
        chk("t3_rf7", dut_rf[7], 32'h33);
        chk("t3_rf0", dut_rf[0], 0);

        // Sustained dual writes: in_ready falls at count=3
        for (int k = 0; k < 4; k++) begin
            cycle(1, 5'(8 + 2 * k), 32'h100 + 32'(2 * k), 1, 5'(9 + 2 * k), 32'h101 + 32'(2 * k));
            if (k == 1) begin
                chk("t4_count3", count, 3);
                chk("t4_ready_low", in_ready, 0);
            end
        end
        idle(12);
        chk("t4_rf15", dut_rf[15], 32'h107);

        // Reset mid-operation discards queued writes
        cycle(1, 5'd20, 32'hE0, 1, 5'd21, 32'hE1);
        cycle(1, 5'd22, 32'hE2, 1, 5'd23, 32'hE3);
        chk("t5_count_pre", count, 3);
        chk("t5_we_pre", we, 1);
        rst = 1'b1;
        @(posedge clk);
        exp_q.delete();
        #1;
        rst = 1'b0;
        chk("t5_we", we, 0);
        chk("t5_count", count, 0);
        chk("t5_pending", pending, 0);
        chk("t5_in_ready", in_ready, 1);
        w0 = n_writes;
        idle(5);
        chk("t5_no_writes", n_writes - w0, 0);
        chk("t5_rf21", dut_rf[21], 0);

        // Random dual-lane traffic with frequent address collisions
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            end
        end
        idle(20);
        chk("drained", exp_q.size(), 0);
        for (int r = 0; r < NREGS; r++) begin
            chk($sformatf("rf_final_%0d", r), dut_rf[r], model_rf[r]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish before 1000000");
        $fatal(1);
    end

endmodule : tb_regfile_wb_queue
`default_nettype wire
